// File: rtl/click_decode_pkg.sv
// click_decode_pkg: shared FSM states, event codes and burst limits for click_decode.
package click_decode_pkg;
   typedef enum logic [1:0] {IDLE, COUNT, WAIT_REL} click_state_t;
   localparam logic [1:0] CODE_LONG   = 2'd0;
   localparam logic [1:0] CODE_SINGLE = 2'd1;
   localparam logic [1:0] CODE_DOUBLE = 2'd2;
   localparam logic [1:0] CODE_TRIPLE = 2'd3;
   localparam int MAX_CLICKS = 3;
endpackage

// File: rtl/click_decode_if.sv
// click_decode_if: key pulse inputs plus valid/ready event output of click_decode.
interface click_decode_if;
   logic       pulse;
   logic       held;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       evt_ready;
   logic       evt_ovf;
   modport master (output pulse, held, evt_ready, input evt_valid, evt_code, evt_ovf);
   modport slave  (input pulse, held, evt_ready, output evt_valid, evt_code, evt_ovf);
endinterface

// File: rtl/click_decode_evt_hold_reg.sv
// evt_hold_reg: one-entry valid/ready event register; a load while occupied sets sticky ovf.
module evt_hold_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [1:0] code_in,
   input  logic       ready,
   output logic       valid,
   output logic [1:0] code,
   output logic       ovf
);
   logic free;
   assign free = !valid || ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         code  <= 2'd0;
         ovf   <= 1'b0;
      end else begin
         if (load && free) begin
            valid <= 1'b1;
            code  <= code_in;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         if (load && !free) ovf <= 1'b1;
      end
   end
endmodule

// File: rtl/click_decode.sv
// click_decode: classifies debounced key pulses into single/double/triple click events.
// Long-press detection (code 0) is compiled in with CLICK_DECODE_LONG_EN.
module click_decode
   import click_decode_pkg::*;
#(
   parameter int WINDOW_CYC = 50_000_000,
   parameter int LONG_CYC   = 100_000_000
) (
   input logic          clk,
   input logic          rst,
   click_decode_if.slave bus
);
   localparam int TMAX = WINDOW_CYC > LONG_CYC ? WINDOW_CYC : LONG_CYC;
   localparam int TW = $clog2(TMAX);
   localparam logic [TW-1:0] WEND = TW'(WINDOW_CYC - 1);
   click_state_t  state;
   logic [1:0]    cnt;
   logic [TW-1:0] timer;
   logic          expire, long_hit, emit;
   logic [1:0]    code;
`ifdef CLICK_DECODE_LONG_EN
   localparam logic [TW-1:0] LEND = TW'(LONG_CYC - 1);
   logic hold_long;
   // A single held click postpones the window and races toward the long-press limit.
   assign hold_long = cnt == 2'd1 && bus.held;
   assign long_hit  = hold_long && timer == LEND;
   assign expire    = !hold_long && timer >= WEND;
`else
   assign long_hit = 1'b0;
   assign expire   = timer == WEND;
`endif
   always_comb begin
      emit = state == COUNT && (bus.pulse ? cnt == 2'(MAX_CLICKS - 1) : (expire || long_hit));
      code = bus.pulse ? CODE_TRIPLE : long_hit ? CODE_LONG : cnt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 2'd0;
         timer <= '0;
      end else begin
         case (state)
            IDLE: if (bus.pulse) begin
               state <= COUNT;
               cnt   <= 2'd1;
               timer <= '0;
            end
            COUNT: if (emit) begin
               state <= long_hit ? WAIT_REL : IDLE;
               cnt   <= 2'd0;
               timer <= '0;
            end else if (bus.pulse) begin
               cnt   <= cnt + 2'd1;
               timer <= '0;
            end else begin
               timer <= timer + TW'(1);
            end
`ifdef CLICK_DECODE_LONG_EN
            WAIT_REL: if (!bus.held) state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
      end
   end
   evt_hold_reg u_hold (
      .clk    (clk),
      .rst    (rst),
      .load   (emit),
      .code_in(code),
      .ready  (bus.evt_ready),
      .valid  (bus.evt_valid),
      .code   (bus.evt_code),
      .ovf    (bus.evt_ovf)
   );
endmodule
